// File: rtl/alu_ctr_seq_if.sv
// Request/result handshake bundle for the ALU control sequencer.
// The requester drives the master side; alu_ctr_seq sits on the slave side.
interface alu_ctr_seq_if #(
  parameter int ALUOP_W = 3,
  parameter int FUNC_W  = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [ALUOP_W-1:0] ALUop;
  logic [FUNC_W-1:0]  func;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         ctr;
  logic               illegal;
  logic               multi;

  modport master (
    output in_valid, ALUop, func, out_ready,
    input  in_ready, out_valid, ctr, illegal, multi
  );

  modport slave (
    input  in_valid, ALUop, func, out_ready,
    output in_ready, out_valid, ctr, illegal, multi
  );
endinterface

// File: rtl/alu_ctr_seq.sv
// ALU control decoder with a valid/ready handshake, multi-cycle op sequencing
// and a saturating counter of accepted illegal requests.
module alu_ctr_seq #(
  parameter int         ALUOP_W = 3,
  parameter int         FUNC_W  = 5,
  parameter logic [7:0] MC_MASK = 8'b0011_0000,
  parameter int         MC_LAT  = 4,
  parameter int         CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_ctr_seq_if.slave     bus,
  output logic             busy,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int LAT_W = $clog2(MC_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_nx_s;
  logic [LAT_W-1:0]   cnt_r;
  logic [2:0]         ctr_r;
  logic               illegal_r;
  logic               multi_r;
  logic [CNT_W-1:0]   illegal_cnt_r;
  logic [ALUOP_W-1:0] aluop_s;
  logic [FUNC_W-1:0]  func_s;
  logic [3:0]         dec_s;
  logic               mc_s;
  logic               in_ready_s;
  logic               accept_s;

  // Returns {legal, ctr}; any undecodable request maps to {0, 000}.
  function automatic logic [3:0] decode(input logic [ALUOP_W-1:0] op,
                                        input logic [FUNC_W-1:0]  fn);
    logic [3:0] r;
    r = 4'b0000;
    if ((op >> 3) != {ALUOP_W{1'b0}}) begin
      r = 4'b0000;
    end else begin
      case (op[2:0])
        3'b000: begin
          if ((fn >> 5) != {FUNC_W{1'b0}}) begin
            r = 4'b0000;
          end else begin
            case (fn[4:0])
              5'b11111: r = 4'b1000;
              5'b11110: r = 4'b1001;
              5'b11100: r = 4'b1011;
              5'b11101: r = 4'b1010;
              5'b11000: r = 4'b1111;
              5'b11011: r = 4'b1100;
              5'b11010: r = 4'b1101;
              5'b10000: r = 4'b1110;
              default:  r = 4'b0000;
            endcase
          end
        end
        3'b001:  r = 4'b1000;
        3'b010:  r = 4'b1011;
        3'b011:  r = 4'b1010;
        3'b100:  r = 4'b1000;
        3'b101:  r = 4'b1000;
        3'b110:  r = 4'b1110;
        3'b111:  r = 4'b1110;
        default: r = 4'b0000;
      endcase
    end
    return r;
  endfunction

  assign aluop_s    = bus.ALUop;
  assign func_s     = bus.func;
  assign dec_s      = decode(aluop_s, func_s);
  assign mc_s       = dec_s[3] & MC_MASK[dec_s[2:0]];
  assign in_ready_s = (state_r == IDLE) | ((state_r == DONE) & bus.out_ready);
  assign accept_s   = bus.in_valid & in_ready_s;

  // Next-state selection; a DONE handoff may chain straight into a new request.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = mc_s ? EXEC : DONE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      EXEC: begin
        if (cnt_r == {LAT_W{1'b0}}) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = EXEC;
        end
      end
      DONE: begin
        if (!bus.out_ready) begin
          state_nx_s = DONE;
        end else if (accept_s) begin
          state_nx_s = mc_s ? EXEC : DONE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, latency counter, result registers and illegal counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= {LAT_W{1'b0}};
      ctr_r         <= 3'b000;
      illegal_r     <= 1'b0;
      multi_r       <= 1'b0;
      illegal_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      if (accept_s) begin
        ctr_r     <= dec_s[2:0];
        illegal_r <= ~dec_s[3];
        multi_r   <= mc_s;
        cnt_r     <= mc_s ? LAT_W'(MC_LAT - 2) : {LAT_W{1'b0}};
        if (!dec_s[3] && (illegal_cnt_r != {CNT_W{1'b1}})) begin
          illegal_cnt_r <= illegal_cnt_r + CNT_W'(1);
        end
      end else if ((state_r == EXEC) && (cnt_r != {LAT_W{1'b0}})) begin
        cnt_r <= cnt_r - LAT_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_r == DONE);
  assign bus.ctr       = ctr_r;
  assign bus.illegal   = illegal_r;
  assign bus.multi     = multi_r;
  assign busy          = (state_r == EXEC);
  assign illegal_cnt   = illegal_cnt_r;

endmodule

// File: tb/tb_alu_ctr_seq.sv
// Directed bench for alu_ctr_seq: decode tables on a default instance and a
// widened instance, plus backpressure, chaining and mid-operation reset sequences.
module tb_alu_ctr_seq;

  typedef struct {
    logic [3:0] aluop;
    logic [5:0] func;
    logic [2:0] ctr;
    logic       ill;
    logic       mul;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy0, busy1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  int         n_cmp = 0;
  int         n_err = 0;
  vec_t       v0[17];
  vec_t       v1[8];
  logic [2:0] b2b_op[4];
  logic [2:0] b2b_ctr[4];

  always #5 clk = ~clk;

  alu_ctr_seq_if #(.ALUOP_W(3), .FUNC_W(5)) b0 ();
  alu_ctr_seq_if #(.ALUOP_W(4), .FUNC_W(6)) b1 ();

  alu_ctr_seq dut0 (
    .clk(clk), .rst(rst), .bus(b0), .busy(busy0), .illegal_cnt(cnt0)
  );

  alu_ctr_seq #(.ALUOP_W(4), .FUNC_W(6), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .bus(b1), .busy(busy1), .illegal_cnt(cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run0(input vec_t v);
    int lat;
    b0.ALUop     = v.aluop[2:0];
    b0.func      = v.func[4:0];
    b0.in_valid  = 1'b1;
    b0.out_ready = 1'b1;
    tick();
    b0.in_valid = 1'b0;
    lat = 0;
    while (!b0.out_valid && lat < 10) begin
      chk("d0_exec_busy", busy0, 1);
      chk("d0_exec_in_ready", b0.in_ready, 0);
      tick();
      lat++;
    end
    chk("d0_latency", lat, v.mul ? 3 : 0);
    chk("d0_ctr", b0.ctr, v.ctr);
    chk("d0_illegal", b0.illegal, v.ill);
    chk("d0_multi", b0.multi, v.mul);
    tick();
    chk("d0_idle_after_handoff", b0.out_valid, 0);
  endtask

  task automatic run1(input vec_t v);
    int lat;
    b1.ALUop     = v.aluop;
    b1.func      = v.func;
    b1.in_valid  = 1'b1;
    b1.out_ready = 1'b1;
    tick();
    b1.in_valid = 1'b0;
    lat = 0;
    while (!b1.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("d1_latency", lat, v.mul ? 3 : 0);
    chk("d1_ctr", b1.ctr, v.ctr);
    chk("d1_illegal", b1.illegal, v.ill);
    chk("d1_multi", b1.multi, v.mul);
    tick();
  endtask

  initial begin
    v0[0]  = '{4'b0001, 6'b000000, 3'b000, 1'b0, 1'b0};
    v0[1]  = '{4'b0010, 6'b000000, 3'b011, 1'b0, 1'b0};
    v0[2]  = '{4'b0011, 6'b000000, 3'b010, 1'b0, 1'b0};
    v0[3]  = '{4'b0100, 6'b000000, 3'b000, 1'b0, 1'b0};
    v0[4]  = '{4'b0101, 6'b000000, 3'b000, 1'b0, 1'b0};
    v0[5]  = '{4'b0110, 6'b000000, 3'b110, 1'b0, 1'b0};
    v0[6]  = '{4'b0111, 6'b000000, 3'b110, 1'b0, 1'b0};
    v0[7]  = '{4'b0000, 6'b011111, 3'b000, 1'b0, 1'b0};
    v0[8]  = '{4'b0000, 6'b011110, 3'b001, 1'b0, 1'b0};
    v0[9]  = '{4'b0000, 6'b011100, 3'b011, 1'b0, 1'b0};
    v0[10] = '{4'b0000, 6'b011101, 3'b010, 1'b0, 1'b0};
    v0[11] = '{4'b0000, 6'b011000, 3'b111, 1'b0, 1'b0};
    v0[12] = '{4'b0000, 6'b011011, 3'b100, 1'b0, 1'b1};
    v0[13] = '{4'b0000, 6'b011010, 3'b101, 1'b0, 1'b1};
    v0[14] = '{4'b0000, 6'b010000, 3'b110, 1'b0, 1'b0};
    v0[15] = '{4'b0000, 6'b000000, 3'b000, 1'b1, 1'b0};
    v0[16] = '{4'b0000, 6'b010001, 3'b000, 1'b1, 1'b0};

    v1[0] = '{4'b1010, 6'b000000, 3'b000, 1'b1, 1'b0};
    v1[1] = '{4'b0000, 6'b111111, 3'b000, 1'b1, 1'b0};
    v1[2] = '{4'b0010, 6'b000000, 3'b011, 1'b0, 1'b0};
    v1[3] = '{4'b0000, 6'b011111, 3'b000, 1'b0, 1'b0};
    v1[4] = '{4'b0000, 6'b011011, 3'b100, 1'b0, 1'b1};
    v1[5] = '{4'b1000, 6'b000000, 3'b000, 1'b1, 1'b0};
    v1[6] = '{4'b0000, 6'b000000, 3'b000, 1'b1, 1'b0};
    v1[7] = '{4'b0000, 6'b110000, 3'b000, 1'b1, 1'b0};

    b2b_op[0] = 3'b001; b2b_ctr[0] = 3'b000;
    b2b_op[1] = 3'b010; b2b_ctr[1] = 3'b011;
    b2b_op[2] = 3'b011; b2b_ctr[2] = 3'b010;
    b2b_op[3] = 3'b111; b2b_ctr[3] = 3'b110;

    // Reset, with a request offered during reset that must not be taken
    b0.in_valid = 1'b1; b0.ALUop = 3'b010; b0.func = 5'b00000; b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.ALUop = 4'b0000; b1.func = 6'b000000; b1.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    b0.in_valid = 1'b0;
    chk("rst_out_valid", b0.out_valid, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_ctr", b0.ctr, 0);
    chk("rst_illegal", b0.illegal, 0);
    chk("rst_multi", b0.multi, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_in_ready", b0.in_ready, 1);
    chk("rst_d1_cnt", cnt1, 0);
    tick();
    chk("rst_no_accept", b0.out_valid, 0);

    for (int i = 0; i < 17; i++) run0(v0[i]);
    chk("d0_illegal_cnt", cnt0, 2);

    // Backpressure: result held 5 cycles while the next request waits
    b0.ALUop = 3'b010; b0.in_valid = 1'b1; b0.out_ready = 1'b0;
    tick();
    b0.ALUop = 3'b110;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_out_valid", b0.out_valid, 1);
      chk("bp_ctr", b0.ctr, 3'b011);
      chk("bp_in_ready", b0.in_ready, 0);
      tick();
    end
    b0.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", b0.in_ready, 1);
    tick();
    chk("bp_chain_valid", b0.out_valid, 1);
    chk("bp_chain_ctr", b0.ctr, 3'b110);
    for (int k = 0; k < 4; k++) begin
      b0.ALUop = b2b_op[k];
      tick();
      chk("b2b_out_valid", b0.out_valid, 1);
      chk("b2b_ctr", b0.ctr, b2b_ctr[k]);
    end
    b0.in_valid = 1'b0;
    tick();
    chk("b2b_drain", b0.out_valid, 0);

    // Reset during the 2nd EXEC cycle discards the multi-cycle op
    b0.ALUop = 3'b000; b0.func = 5'b11011; b0.in_valid = 1'b1; b0.out_ready = 1'b1;
    tick();
    b0.in_valid = 1'b0;
    chk("mr_exec1_busy", busy0, 1);
    tick();
    chk("mr_exec2_busy", busy0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_busy", busy0, 0);
    chk("mr_out_valid", b0.out_valid, 0);
    chk("mr_cnt", cnt0, 0);
    chk("mr_multi", b0.multi, 0);
    chk("mr_in_ready", b0.in_ready, 1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("mr_no_result", b0.out_valid, 0);
    end

    // Widened instance, including counter saturation at CNT_W=2
    for (int i = 0; i < 8; i++) run1(v1[i]);
    chk("d1_illegal_cnt_sat", cnt1, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
